// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - display timing generator and pixel output stage (optional VID_UNDERRUN_FILL_EN)
module vid_timing_gen #(
    parameter int CW = 13,
    parameter int DW = 8,
    parameter int PW = 6
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_en,
    input  logic [PW-1:0]   i_pcnt,
    input  logic [CW-1:0]   i_hsize,
    input  logic [CW-1:0]   i_hend,
    input  logic [CW-1:0]   i_hsync_start,
    input  logic [CW-1:0]   i_hsync_end,
    input  logic [CW-1:0]   i_vsize,
    input  logic [CW-1:0]   i_vend,
    input  logic [CW-1:0]   i_vsync_start,
    input  logic [CW-1:0]   i_vsync_end,
    input  logic [3*DW-1:0] i_fifo_rdata,
    input  logic            i_fifo_empty,
    output logic            o_fifo_rd,
    output logic            o_hsync,
    output logic            o_hblank,
    output logic            o_vsync,
    output logic            o_vblank,
    output logic [DW-1:0]   o_r,
    output logic [DW-1:0]   o_g,
    output logic [DW-1:0]   o_b,
    output logic            o_frame_start,
    output logic            o_line_start,
    output logic            o_underrun
);

    logic [PW-1:0]   r_pcnt_s;
    logic [CW-1:0]   r_hsize_s, r_hend_s, r_hss_s, r_hse_s;
    logic [CW-1:0]   r_vsize_s, r_vend_s, r_vss_s, r_vse_s;
    logic [PW-1:0]   r_pc;
    logic [CW-1:0]   r_hcnt, r_vcnt;
    logic            r_hsync, r_vsync, r_hblank, r_vblank;
    logic            r_frame_start, r_line_start;
    logic [3*DW-1:0] r_rgb;

    logic w_tick, w_h_wrap, w_v_wrap, w_h_in, w_v_in, w_active, w_h_sync, w_v_sync;

    assign w_tick   = i_en & (r_pc == r_pcnt_s);
    // Compare one bit wider so hcnt+1 cannot overflow past an hend near full scale.
    assign w_h_wrap = ({1'b0, r_hcnt} + (CW+1)'(1)) >= {1'b0, r_hend_s};
    assign w_v_wrap = ({1'b0, r_vcnt} + (CW+1)'(1)) >= {1'b0, r_vend_s};
    assign w_h_in   = r_hcnt < r_hsize_s;
    assign w_v_in   = r_vcnt < r_vsize_s;
    assign w_active = w_h_in & w_v_in;
    assign w_h_sync = (r_hcnt >= r_hss_s) & (r_hcnt < r_hse_s);
    assign w_v_sync = (r_vcnt >= r_vss_s) & (r_vcnt < r_vse_s);

    assign o_fifo_rd = w_tick & w_active & ~i_fifo_empty;

    // Timing fields only change at the frame boundary while running.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pcnt_s  <= '0;
            r_hsize_s <= '0;
            r_hend_s  <= '0;
            r_hss_s   <= '0;
            r_hse_s   <= '0;
            r_vsize_s <= '0;
            r_vend_s  <= '0;
            r_vss_s   <= '0;
            r_vse_s   <= '0;
        end else if (!i_en || (w_tick && w_h_wrap && w_v_wrap)) begin
            r_pcnt_s  <= i_pcnt;
            r_hsize_s <= i_hsize;
            r_hend_s  <= i_hend;
            r_hss_s   <= i_hsync_start;
            r_hse_s   <= i_hsync_end;
            r_vsize_s <= i_vsize;
            r_vend_s  <= i_vend;
            r_vss_s   <= i_vsync_start;
            r_vse_s   <= i_vsync_end;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc   <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!i_en) begin
            r_pc   <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_tick) begin
            r_pc   <= '0;
            r_hcnt <= w_h_wrap ? '0 : r_hcnt + CW'(1);
            if (w_h_wrap) begin
                r_vcnt <= w_v_wrap ? '0 : r_vcnt + CW'(1);
            end
        end else begin
            r_pc <= r_pc + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (!i_en) begin
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_line_start  <= w_tick & (r_hcnt == '0);
            r_frame_start <= w_tick & (r_hcnt == '0) & (r_vcnt == '0);
            if (w_tick) begin
                r_hblank <= ~w_h_in;
                r_vblank <= ~w_v_in;
                r_hsync  <= w_h_sync;
                r_vsync  <= w_v_sync;
`ifdef VID_UNDERRUN_FILL_EN
                if (!w_active)
                    r_rgb <= '0;
                else if (i_fifo_empty)
                    r_rgb <= {{(2*DW){1'b0}}, {DW{1'b1}}};
                else
                    r_rgb <= i_fifo_rdata;
`else
                r_rgb <= w_active ? i_fifo_rdata : '0;
`endif
            end
        end
    end

`ifdef VID_UNDERRUN_FILL_EN
    logic r_underrun;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_underrun <= 1'b0;
        else if (!i_en)
            r_underrun <= 1'b0;
        else if (w_tick && w_active && i_fifo_empty)
            r_underrun <= 1'b1;
    end

    assign o_underrun = r_underrun;
`else
    assign o_underrun = 1'b0;
`endif

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_hblank      = r_hblank;
    assign o_vblank      = r_vblank;
    assign o_r           = r_rgb[3*DW-1:2*DW];
    assign o_g           = r_rgb[2*DW-1:DW];
    assign o_b           = r_rgb[DW-1:0];
    assign o_frame_start = r_frame_start;
    assign o_line_start  = r_line_start;

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb/tb_vid_timing_gen.sv - directed vector bench for vid_timing_gen
module tb_vid_timing_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [5:0]  pcnt = '0;
    logic [12:0] hsize = '0, hend = '0, hsync_start = '0, hsync_end = '0;
    logic [12:0] vsize = '0, vend = '0, vsync_start = '0, vsync_end = '0;
    logic [23:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rd, hsync, hblank, vsync, vblank, frame_start, line_start, underrun;
    logic [7:0]  r, g, b;

    logic [23:0] mem [0:127];
    int          rd_ptr = 0;
    int          fill_cnt = 0;
    logic        fifo_clr = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vid_timing_gen dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_pcnt(pcnt),
        .i_hsize(hsize), .i_hend(hend), .i_hsync_start(hsync_start), .i_hsync_end(hsync_end),
        .i_vsize(vsize), .i_vend(vend), .i_vsync_start(vsync_start), .i_vsync_end(vsync_end),
        .i_fifo_rdata(fifo_rdata), .i_fifo_empty(fifo_empty), .o_fifo_rd(fifo_rd),
        .o_hsync(hsync), .o_hblank(hblank), .o_vsync(vsync), .o_vblank(vblank),
        .o_r(r), .o_g(g), .o_b(b), .o_frame_start(frame_start), .o_line_start(line_start),
        .o_underrun(underrun)
    );

    // First-word-fall-through FIFO model over a preloaded pixel array
    assign fifo_empty = (rd_ptr >= fill_cnt);
    assign fifo_rdata = mem[rd_ptr[6:0]];
    always @(posedge clk) begin
        if (fifo_clr) rd_ptr <= 0;
        else if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    typedef struct {
        int          k;
        logic        hb, vb, hs, vs, ls, fs;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] all_out();
        return {fifo_rd, hsync, vsync, hblank, vblank, frame_start, line_start, underrun, r, g, b};
    endfunction

    function automatic logic [29:0] tbl_out();
        return {hblank, vblank, hsync, vsync, line_start, frame_start, r, g, b};
    endfunction

    task automatic start(input int pc, input int hs_sz, input int vs_end);
        @(negedge clk);
        en = 1'b0; pcnt = 6'(pc);
        hsize = 13'(hs_sz); hend = 13'd8; hsync_start = 13'd5; hsync_end = 13'd6;
        vsize = 13'd2; vend = 13'd4; vsync_start = 13'd3; vsync_end = 13'(vs_end);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0; en = 1'b1;
    endtask

    localparam logic [31:0] IDLE = 32'h1800_0000;

    initial begin
        int hs_cnt, vs_cnt, fs_cnt, fs_first, fs_second;

        for (int i = 0; i < 128; i++) mem[i] = 24'h100000 + 24'(i);

        tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h100000};
        tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h100001};
        tbl[2]  = '{3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h100003};
        tbl[3]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[4]  = '{5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[5]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[6]  = '{7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[7]  = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h100004};
        tbl[8]  = '{11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h100007};
        tbl[9]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[10] = '{16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[11] = '{21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[12] = '{24, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[13] = '{31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[14] = '{32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h100008};
        tbl[15] = '{35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h10000B};
        tbl[16] = '{41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h10000D};

        // Reset and idle with en low
        repeat (3) @(negedge clk);
        check("reset_state", all_out(), IDLE);
        reset_n = 1'b1;
        fill_cnt = 128;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_en0", all_out(), IDLE);
        end

        // Base geometry, pcnt=0
        start(0, 4, 3);
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            for (int j = 0; j < 17; j++)
                if (tbl[j].k == k)
                    check($sformatf("vec_k%0d", k), 32'(tbl_out()),
                          32'({tbl[j].hb, tbl[j].vb, tbl[j].hs, tbl[j].vs, tbl[j].ls, tbl[j].fs, tbl[j].rgb}));
            if (k < 8 && hsync) hs_cnt++;
            if (vsync) vs_cnt++;
            if (frame_start) fs_cnt++;
            if (k == 31) check("pops_frame0", 32'(rd_ptr), 32'd8);
        end
        check("hsync_per_line", 32'(hs_cnt), 32'd1);
        check("vsync_never", 32'(vs_cnt), 32'd0);
        check("frame_start_count", 32'(fs_cnt), 32'd2);

        // pcnt=3: each pixel held 4 clocks, 128-clock frame
        start(3, 4, 3);
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n == 2) check("p3_pre_tick_hblank", 32'(hblank), 32'd1);
            if (n >= 3 && n <= 6) check($sformatf("p3_hold_rgb_n%0d", n), 32'({r, g, b}), 32'h100000);
            if (n == 7) check("p3_rgb_px1", 32'({r, g, b}), 32'h100001);
            if (n == 3) check("p3_line_start_on", 32'(line_start), 32'd1);
            if (n == 4) check("p3_line_start_off", 32'(line_start), 32'd0);
            if (n == 19) check("p3_hblank_px4", 32'(hblank), 32'd1);
            if (n == 130) check("p3_pops_frame0", 32'(rd_ptr), 32'd8);
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
        end
        check("p3_first_frame_start", 32'(fs_first), 32'd3);
        check("p3_frame_period", 32'(fs_second - fs_first), 32'd128);
        check("p3_frame_start_count", 32'(fs_cnt), 32'd3);

        // hsize change mid-frame, vsync on line 3
        start(0, 4, 4);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 10) hsize = 13'd6;
            if (k == 12) check("mid_hblank_old", 32'(hblank), 32'd1);
            if (k == 23) check("vsync_before", 32'(vsync), 32'd0);
            if (k == 24) check("vsync_first", 32'(vsync), 32'd1);
            if (k == 31) check("vsync_last", 32'(vsync), 32'd1);
            if (k == 32) check("vsync_after", 32'(vsync), 32'd0);
            if (k == 31) check("mid_pops_frame0", 32'(rd_ptr), 32'd8);
            if (k == 36) check("new_rgb_h4", 32'({hblank, r, g, b}), {7'd0, 1'b0, 24'h10000C});
            if (k == 37) check("new_hblank_h5", 32'(hblank), 32'd0);
            if (k == 38) check("new_hblank_h6", 32'(hblank), 32'd1);
            if (k == 63) check("new_pops_total", 32'(rd_ptr), 32'd20);
        end

        // FIFO runs dry at an active pixel, then en falls mid-line
        fill_cnt = 2;
        start(0, 4, 3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) check("ur_no_pop", 32'(fifo_rd), 32'd0);
`ifdef VID_UNDERRUN_FILL_EN
            if (k == 2) check("ur_fill", 32'({underrun, r, g, b}), {7'd0, 1'b1, 24'h0000FF});
            if (k == 3) check("ur_sticky", 32'({underrun, r, g, b}), {7'd0, 1'b1, 24'h100002});
`else
            if (k == 2) check("ur_passthru", 32'({underrun, r, g, b}), {7'd0, 1'b0, 24'h100002});
            if (k == 3) check("ur_refill", 32'({underrun, r, g, b}), {7'd0, 1'b0, 24'h100002});
`endif
            if (k == 2) fill_cnt = 128;
            if (k == 3) check("ur_ptr", 32'(rd_ptr), 32'd3);
        end
        check("pre_fall_rd", 32'(fifo_rd), 32'd1);
        en = 1'b0;
        #1;
        check("fall_rd_immediate", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        check("fall_outputs", all_out(), IDLE);
        check("fall_no_pop", 32'(rd_ptr), 32'd3);

        // Asynchronous reset mid-line
        start(0, 4, 3);
        repeat (9) @(negedge clk);
        check("pre_reset_active", 32'(hblank), 32'd0);
        #1 reset_n = 1'b0;
        #1 check("async_reset", all_out(), IDLE);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Display timing generator and pixel output stage for the video controller. Consumes the programmed control, horizontal and vertical timing values and the 24-bit RGB pixel FIFO filled by the data-fetch engine. Produces hsync/hblank/vsync/vblank and R/G/B at the pixel rate, plus frame and line strobes that the fetch engine uses to rewind and advance its address.

## Interface
- CW, 13, width of h/v counters and timing fields
- DW, 8, bits per colour channel
- PW, 6, width of pixel divider field

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  controller enable (cr.en)
- pcnt  in  PW  pixel divider; pixel period = pcnt+1 clocks
- hsize, hend, hsync_start, hsync_end  in  CW each  horizontal timing (h1/h2 fields)
- vsize, vend, vsync_start, vsync_end  in  CW each  vertical timing (v1/v2 fields)
- fifo_rdata  in  3*DW  first-word-fall-through pixel {R,G,B}
- fifo_empty  in  1  pixel FIFO empty
- fifo_rd  out  1  pop one pixel this clock
- hsync, hblank, vsync, vblank  out  1 each  timing outputs, active high
- R, G, B  out  DW each  pixel colour
- frame_start  out  1  one-clock pulse at pixel (0,0)
- line_start  out  1  one-clock pulse at hcnt=0 of every line
- underrun  out  1  sticky: active pixel needed while FIFO empty

## Operation
- Shadow registers hold all timing fields and pcnt.
  - While en=0: they load every clock.
  - While en=1: they load only on the pixel tick that wraps both counters to (0,0).
  - Mid-frame register writes therefore take effect at the next frame.
- Prescaler pc (PW bits):
  - tick = en & (pc == pcnt_shadow).
  - On tick, pc <= 0; otherwise, if en, pc <= pc+1.
- hcnt (CW bits), on tick:
  - Wraps to 0 when {1'b0,hcnt}+1 >= hend (CW+1-bit compare); otherwise increments.
  - hend of 0 or 1 holds hcnt at 0.
- vcnt: advances only on ticks where hcnt wraps, using the same rule with vend.
- Decode from the current counters:
  - active = (hcnt < hsize) & (vcnt < vsize).
  - h_sync = (hcnt >= hsync_start) & (hcnt < hsync_end).
  - v_sync = (vcnt >= vsync_start) & (vcnt < vsync_end).
  - hsync_end <= hsync_start means no sync pulse (same for vertical).
- fifo_rd = tick & active & ~fifo_empty (combinational).
- On each tick the registered outputs load:
  - hblank <= ~(hcnt<hsize); vblank <= ~(vcnt<vsize); hsync <= h_sync; vsync <= v_sync.
  - {R,G,B} <= active ? fifo_rdata : 0.
- Between ticks, registered outputs hold their values.
- frame_start and line_start are registered pulses, asserted for one clock after a tick with hcnt=0 (line_start) and additionally vcnt=0 (frame_start).
- en falling:
  - Next edge clears pc, hcnt, vcnt and outputs to reset values.
  - fifo_rd is held 0 immediately.
- en rising: first tick occurs after pcnt+1 clocks, at pixel (0,0).

## Timing
- Reset values:
  - fifo_rd=0, hsync=0, vsync=0, hblank=1, vblank=1.
  - R=G=B=0, frame_start=0, line_start=0, underrun=0.
  - Counters and prescaler 0.
- Latency:
  - Timing outputs and RGB lag the counter state by one clock.
  - The pixel popped by fifo_rd appears on R/G/B the following clock, aligned with its blank/sync.
- Simultaneous tick with en falling: en wins; no pop, counters cleared.
- Reset mid-frame: all state returns to reset values asynchronously; no partial pop.
- Frame period = (pcnt+1)·hend·vend clocks for hend, vend ≥ 1.

## Configuration
- VID_UNDERRUN_FILL_EN defined:
  - An active tick with fifo_empty=1 loads {R,G,B} = 24'h0000FF (blue).
  - underrun sets and stays set until reset_n or en=0.
  - fifo_rd stays 0 on that tick.
- VID_UNDERRUN_FILL_EN undefined:
  - An active tick with fifo_empty=1 loads fifo_rdata unchanged.
  - underrun is tied 0.

## Test plan
- Reset, en=0 -> hblank=vblank=1, hsync=vsync=0, RGB=0, fifo_rd=0 for 100 clocks.
- en=1, pcnt=0, hsize=4, hend=8, hsync 5..6, vsize=2, vend=4, vsync 3..3, FIFO preloaded with incrementing pixels:
  - Exactly 8 pops per frame.
  - hsync high for 1 clock per 8-clock line.
  - vsync never asserts.
  - frame_start every 32 clocks.
  - RGB matches pop order.
- pcnt=3, same geometry -> every output held 4 clocks per pixel; frame period 128 clocks.
- Change hsize to 6 mid-frame -> current frame still 4 pixels per line; next frame 6.
- With VID_UNDERRUN_FILL_EN, FIFO empty at an active pixel:
  - RGB=0x0000FF and underrun=1, with no pop.
  - Refilling the FIFO leaves underrun sticky.
  - en=0 clears underrun.
- Assert reset_n low mid-line -> all outputs take reset values with no clock edge required.
